rf_mp: RTL and testbench
========================

# rf_mp

Parametrised multi-port register file for the pipelined CPU: configurable data width, depth and read-port count, one general write port plus a dedicated link-register write port, same-cycle write-to-read forwarding, and a sequential clear engine that zeroes the array after reset. It sits in the decode stage: read ports feed operand selection, the write port is driven from writeback, and the link port is driven by jump-and-link.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (1..4)
- LINK_REG, 31, index written by the link port; must satisfy 0 < LINK_REG < DEPTH

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational, same packing
- wr_en  in  1  general write enable
- wr_addr  in  ADDR_W  general write address
- wr_data  in  DATA_W  general write data
- link_en  in  1  link write enable; writes link_data to LINK_REG
- link_data  in  DATA_W  return address (PC+8 computed upstream)
- busy  out  1  high while reset or clear is in progress

## Operation
- Entry 0 hardwired zero: never written, always reads 0, including via forwarding.
- FSM states: CLEAR, IDLE. rst=1 forces CLEAR with clear pointer = 1. In CLEAR each rising edge with rst=0 writes 0 to entry [pointer] and increments it; the edge that clears DEPTH-1 moves to IDLE.
- While busy: all rd_data ports return 0; wr_en and link_en are ignored (dropped, no stall). Upstream holds the pipeline on busy.
- In IDLE: wr_en && wr_addr!=0 writes wr_data; link_en writes link_data to LINK_REG.
- Collision (wr_en, link_en, wr_addr==LINK_REG same cycle): link port wins.
- Reads: rd_data[i] = 0 if rd_addr[i]==0, else forwarded value (see Configuration), else array[rd_addr[i]]. Link forwarding has priority over general forwarding, mirroring the write priority.
- Read ports are independent; any ports may address the same entry.

## Timing
- Read latency 0 (combinational from rd_addr and array/write inputs).
- Write latency 1 edge: data captured on rising edge, visible in array after it.
- Clear duration: exactly DEPTH-1 rising edges with rst=0; busy deasserts after the (DEPTH-1)th edge (31 cycles for defaults).
- Reset values: busy=1, rd_data=0 for every port, FSM=CLEAR, pointer=1. Array contents are not reset directly; they are zeroed by CLEAR.
- rst asserted mid-CLEAR: pointer returns to 1, clear restarts, full DEPTH-1 cycles again.
- rst asserted in IDLE: same as power-on; any write presented that cycle is dropped.

## Configuration
- RF_BYPASS_EN defined: a read whose address matches an enabled, accepted write in the same cycle returns the write data (write-through forwarding; link data if both match).
- RF_BYPASS_EN undefined: reads return stored array contents only; a value written at edge N is first readable in the cycle after edge N. Pipeline hazard logic must then cover the extra cycle.

## Structure
- Shared package rf_pkg: state enum (RF_CLEAR, RF_IDLE), default DATA_W/ADDR_W/LINK_REG constants used by decode and writeback.
- One sub-module: rf_clear_fsm (state register, clear pointer, busy, clear write-enable/address outputs). Array, write muxing and read/forward logic stay in rf_mp.

## Test plan
- Reset 1 cycle then release, defaults -> busy high for exactly 31 edges; all rd_data 0 throughout; entries 1..31 read 0 after.
- IDLE: write 0xDEADBEEF to r5, next cycle read r5 on both ports -> 0xDEADBEEF on both; write 0x1234 to r0 -> r0 still reads 0.
- Simultaneous wr_en (addr 31, 0xAAAA0000) and link_en (0x00400008) -> r31 = 0x00400008; with RF_BYPASS_EN same-cycle read of r31 returns 0x00400008.
- Same-cycle write r7=0x55 and read r7: with RF_BYPASS_EN -> 0x55 that cycle; without -> old value (0) that cycle, 0x55 next cycle.
- Write during busy (wr_en r3=0x77 at clear cycle 10) -> dropped; r3 reads 0 after clear.
- Reassert rst at clear cycle 15 -> pointer restarts; busy stays high 31 further edges after release; NUM_RD=4, DATA_W=64 build repeats scenario 2 with all four ports.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file types and default geometry used by decode and writeback.
package rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_LINK_REG = 31;

endpackage

// File: rtl/rf_clear_fsm.sv
// Post-reset clear sequencer: walks entries 1..DEPTH-1 writing zero, holds busy until done.
//  state    | meaning
//  RF_CLEAR | zeroing entry [ptr] each edge; reads/writes blocked
//  RF_IDLE  | array valid; normal operation
module rf_clear_fsm
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RF_CLEAR;
            ptr_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_we_o   = 1'b0;
        clr_addr_o = ptr_q;
        // rst counts as busy so a write presented alongside reset is dropped
        busy_o     = rst_i || (state_q == RF_CLEAR);
        if (!rst_i && state_q == RF_CLEAR) begin
            clr_we_o = 1'b1;
            ptr_d    = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) begin
                state_d = RF_IDLE;
            end
        end
    end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with link-register write port and post-reset clear.
// Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module rf_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = RF_LINK_REG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     link_en,
    input  logic [DATA_W-1:0]        link_data,
    output logic                     busy
);

    localparam int                DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_acc, link_acc;

    rf_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
        .clk_i      (clk),
        .rst_i      (rst),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign wr_acc   = wr_en && !busy && (wr_addr != '0);
    assign link_acc = link_en && !busy;

    // Link write is issued last so it overrides a general write to LINK_REG.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else begin
            if (wr_acc) begin
                mem_q[wr_addr] <= wr_data;
            end
            if (link_acc) begin
                mem_q[LINK_A] <= link_data;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

        always_comb begin
            rd_data[gi*DATA_W +: DATA_W] = '0;
            if (!busy && ra != '0) begin
`ifdef RF_BYPASS_EN
                if (link_acc && ra == LINK_A) begin
                    rd_data[gi*DATA_W +: DATA_W] = link_data;
                end else if (wr_acc && ra == wr_addr) begin
                    rd_data[gi*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data[gi*DATA_W +: DATA_W] = mem_q[ra];
                end
`else
                rd_data[gi*DATA_W +: DATA_W] = mem_q[ra];
`endif
            end
        end
    end

endmodule

// File: tb/tb_rf_mp.sv
// Directed table-driven bench for rf_mp: default build plus a 4-port 64-bit instance.
module tb_rf_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        link_en;
    logic [31:0] link_data;
    logic        busy;

    logic [19:0]  rd_addr4;
    logic [255:0] rd_data4;
    logic [63:0]  wr_data4;
    logic [63:0]  link_data4;
    logic         busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_mp dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .link_en(link_en), .link_data(link_data), .busy(busy)
    );

    rf_mp #(.DATA_W(64), .NUM_RD(4)) dut4 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data4),
        .link_en(link_en), .link_data(link_data4), .busy(busy4)
    );

    typedef struct {
        logic [4:0]  ra0, ra1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        le;
        logic [31:0] ld;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ext(input logic [31:0] x);
        return (x == 32'h0) ? 64'h0 : {~x, x};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addr(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr  = {a1, a0};
        rd_addr4 = {a1, a0, a1, a0};
    endtask

    task automatic drive_wr(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic le, input logic [31:0] ld);
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        wr_data4   = {~wd, wd};
        link_en    = le;
        link_data  = ld;
        link_data4 = {~ld, ld};
    endtask

    task automatic chk_zero_all(input string name);
        chk(name, {63'h0, (rd_data != 64'h0) || (rd_data4 != 256'h0)}, 64'h0);
    endtask

    // Counts edges until both instances drop busy; optionally injects a write at edge wr_at.
    task automatic count_clear(input int wr_at, output int n);
        logic zero_ok;
        n = 0;
        zero_ok = 1'b1;
        while ((busy || busy4) && n < 100) begin
            if (rd_data != 64'h0 || rd_data4 != 256'h0) zero_ok = 1'b0;
            if (n == wr_at) drive_wr(1'b1, 5'd3, 32'h77, 1'b0, 32'h0);
            else            drive_wr(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
            #1;
            step();
            n++;
        end
        drive_wr(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        chk("rd_zero_while_busy", {63'h0, zero_ok}, 64'h1);
    endtask

    initial begin
        int n;
        logic [31:0] bp_r5, bp_r31a, bp_r7, bp_r31b, bp_r5b, bp_r31c;
`ifdef RF_BYPASS_EN
        bp_r5 = 32'hDEADBEEF; bp_r31a = 32'h00400008; bp_r7 = 32'h55;
        bp_r31b = 32'h100;    bp_r5b = 32'h11;        bp_r31c = 32'h200;
`else
        bp_r5 = 32'h0;        bp_r31a = 32'h0;        bp_r7 = 32'h0;
        bp_r31b = 32'h00400008; bp_r5b = 32'hDEADBEEF; bp_r31c = 32'h100;
`endif
        //          ra0    ra1    we    wa     wd             le    ld             e0            e1
        vecs[0]  = '{5'd3,  5'd5,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,        32'h0};
        vecs[1]  = '{5'd5,  5'd5,  1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 32'h0,         bp_r5,        bp_r5};
        vecs[2]  = '{5'd5,  5'd5,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3]  = '{5'd0,  5'd0,  1'b1, 5'd0,  32'h1234,      1'b0, 32'h0,         32'h0,        32'h0};
        vecs[4]  = '{5'd0,  5'd5,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,        32'hDEADBEEF};
        vecs[5]  = '{5'd31, 5'd31, 1'b1, 5'd31, 32'hAAAA0000,  1'b1, 32'h00400008,  bp_r31a,      bp_r31a};
        vecs[6]  = '{5'd31, 5'd1,  1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h00400008, 32'h0};
        vecs[7]  = '{5'd7,  5'd7,  1'b1, 5'd7,  32'h55,        1'b0, 32'h0,         bp_r7,        bp_r7};
        vecs[8]  = '{5'd7,  5'd31, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h55,       32'h00400008};
        vecs[9]  = '{5'd31, 5'd5,  1'b0, 5'd0,  32'h0,         1'b1, 32'h100,       bp_r31b,      32'hDEADBEEF};
        vecs[10] = '{5'd5,  5'd31, 1'b1, 5'd5,  32'h11,        1'b1, 32'h200,       bp_r5b,       bp_r31c};
        vecs[11] = '{5'd5,  5'd31, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h11,       32'h200};

        rst = 1'b1;
        drive_addr(5'd1, 5'd31);
        drive_wr(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        step();
        chk("reset_busy", {62'h0, busy, busy4}, 64'h3);
        chk_zero_all("reset_rd_zero");

        rst = 1'b0;
        drive_addr(5'd3, 5'd3);
        count_clear(10, n);
        chk("clear_edges", 64'(n), 64'd31);

        for (int a = 1; a < 32; a++) begin
            drive_addr(5'(a), 5'(a));
            #1;
            if (rd_data != 64'h0 || rd_data4 != 256'h0) begin
                chk("entry_zero_after_clear", 64'(a), 64'h0);
            end
        end
        chk("busy_low_idle", {62'h0, busy, busy4}, 64'h0);

        for (int i = 0; i < 12; i++) begin
            drive_addr(vecs[i].ra0, vecs[i].ra1);
            drive_wr(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].le, vecs[i].ld);
            #1;
            chk($sformatf("vec%0d_p0", i), {32'h0, rd_data[31:0]},  {32'h0, vecs[i].e0});
            chk($sformatf("vec%0d_p1", i), {32'h0, rd_data[63:32]}, {32'h0, vecs[i].e1});
            chk($sformatf("vec%0d_w_p0", i), rd_data4[63:0],    ext(vecs[i].e0));
            chk($sformatf("vec%0d_w_p1", i), rd_data4[127:64],  ext(vecs[i].e1));
            chk($sformatf("vec%0d_w_p2", i), rd_data4[191:128], ext(vecs[i].e0));
            chk($sformatf("vec%0d_w_p3", i), rd_data4[255:192], ext(vecs[i].e1));
            step();
        end
        drive_wr(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);

        // Reset in IDLE with a write presented: write dropped, full clear follows.
        rst = 1'b1;
        drive_wr(1'b1, 5'd9, 32'h99, 1'b1, 32'h999);
        drive_addr(5'd9, 5'd5);
        #1;
        chk("rst_idle_busy", {62'h0, busy, busy4}, 64'h3);
        chk_zero_all("rst_idle_rd_zero");
        step();
        rst = 1'b0;
        drive_wr(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 15; k++) step();
        chk("mid_clear_busy", {62'h0, busy, busy4}, 64'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_clear(-1, n);
        chk("restart_clear_edges", 64'(n), 64'd31);

        drive_addr(5'd9, 5'd5);
        #1;
        chk("r9_dropped", rd_data, 64'h0);
        drive_addr(5'd31, 5'd7);
        #1;
        chk("r31_r7_cleared", rd_data, 64'h0);
        chk("wide_cleared", rd_data4[127:0], 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
